// File: rtl/counter_multidigit_sevenseg.sv
// Multi-digit BCD/hex up/down counter with wrap carry pulse and a time-multiplexed
// seven-segment scan that presents one digit at a time on a shared segment bus.
module counter_multidigit_sevenseg #(
    parameter int DIGITS   = 4,
    parameter int DECIMAL  = 1,
    parameter int SCAN_DIV = 4,
    parameter int LZ_BLANK = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                carry,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_sel
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [3:0]       MAX_DIGIT = (DECIMAL != 0) ? 4'd9 : 4'd15;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE  = PRE_W'(SCAN_DIV - 1);

    logic [4*DIGITS-1:0] count_r;
    logic [4*DIGITS-1:0] step_s;
    logic [4*DIGITS-1:0] load_s;
    logic                carry_r;
    logic                wrap_s;
    logic [PRE_W-1:0]    prescaler_r;
    logic [IDX_W-1:0]    scan_idx_r;
    logic [3:0]          cur_digit_s;
    logic                upper_nonzero_s;
    logic [6:0]          seg_s;
    logic [DIGITS-1:0]   dig_sel_s;

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'h0:    seg_encode = 7'b1111110;
            4'h1:    seg_encode = 7'b0110000;
            4'h2:    seg_encode = 7'b1101101;
            4'h3:    seg_encode = 7'b1111001;
            4'h4:    seg_encode = 7'b0110011;
            4'h5:    seg_encode = 7'b1011011;
            4'h6:    seg_encode = 7'b1011111;
            4'h7:    seg_encode = 7'b1110000;
            4'h8:    seg_encode = 7'b1111111;
            4'h9:    seg_encode = 7'b1111011;
            4'hA:    seg_encode = 7'b1110111;
            4'hB:    seg_encode = 7'b0011111;
            4'hC:    seg_encode = 7'b1001110;
            4'hD:    seg_encode = 7'b0111101;
            4'hE:    seg_encode = 7'b1001111;
            4'hF:    seg_encode = 7'b1000111;
            default: seg_encode = 7'b0000000;
        endcase
    endfunction

    // Ripple the +1/-1 through the digits; a chain still set past the top digit is a full wrap.
    always_comb begin
        logic       chain;
        logic [3:0] d;
        step_s = count_r;
        chain  = 1'b1;
        d      = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count_r[4*i +: 4];
            if (!chain) begin
                step_s[4*i +: 4] = d;
            end else if (up) begin
                if (d == MAX_DIGIT) begin
                    step_s[4*i +: 4] = 4'd0;
                end else begin
                    step_s[4*i +: 4] = d + 4'd1;
                    chain = 1'b0;
                end
            end else begin
                if (d == 4'd0) begin
                    step_s[4*i +: 4] = MAX_DIGIT;
                end else begin
                    step_s[4*i +: 4] = d - 4'd1;
                    chain = 1'b0;
                end
            end
        end
        wrap_s = chain;
    end

    // In BCD mode an out-of-range nibble loads as zero so the count never leaves 0-9.
    always_comb begin
        load_s = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if ((DECIMAL != 0) && (load_val[4*i +: 4] > 4'd9)) begin
                load_s[4*i +: 4] = 4'd0;
            end else begin
                load_s[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Count and carry register: reset > load > enable > hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            carry_r <= 1'b0;
        end else if (load) begin
            count_r <= load_s;
            carry_r <= 1'b0;
        end else if (enable) begin
            count_r <= step_s;
            carry_r <= wrap_s;
        end else begin
            carry_r <= 1'b0;
        end
    end

    // Free-running scan prescaler and digit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler_r <= '0;
            scan_idx_r  <= '0;
        end else if (prescaler_r == LAST_PRE) begin
            prescaler_r <= '0;
            scan_idx_r  <= (scan_idx_r == LAST_IDX) ? '0 : scan_idx_r + IDX_W'(1);
        end else begin
            prescaler_r <= prescaler_r + PRE_W'(1);
        end
    end

    // Select the scanned digit and decide whether it is a blanked leading zero.
    always_comb begin
        cur_digit_s     = 4'd0;
        upper_nonzero_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == scan_idx_r) begin
                cur_digit_s = count_r[4*i +: 4];
            end else begin
                cur_digit_s = cur_digit_s;
            end
            upper_nonzero_s = upper_nonzero_s |
                ((IDX_W'(i) >= scan_idx_r) && (count_r[4*i +: 4] != 4'd0));
        end
        if ((LZ_BLANK != 0) && (scan_idx_r != '0) && !upper_nonzero_s) begin
            seg_s = 7'b0000000;
        end else begin
            seg_s = seg_encode(cur_digit_s);
        end
        dig_sel_s = DIGITS'(1) << scan_idx_r;
    end

    assign count   = count_r;
    assign carry   = carry_r;
    assign seg     = seg_s;
    assign dig_sel = dig_sel_s;
endmodule

// File: tb/tb_counter_multidigit_sevenseg.sv
// Bench for counter_multidigit_sevenseg: four configurations share one stimulus stream
// and are compared each cycle against an integer-valued reference model.
module tb_counter_multidigit_sevenseg;
    localparam int NI = 4;
    localparam int CFG_DIG [NI] = '{2, 2, 4, 4};
    localparam int CFG_DEC [NI] = '{1, 0, 1, 0};
    localparam int CFG_DIV [NI] = '{2, 1, 4, 3};
    localparam int CFG_LZ  [NI] = '{0, 0, 0, 1};
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
        7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    localparam logic [6:0] SCAN_0123 [4] = '{7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};

    logic        clk = 1'b0;
    logic        reset, enable, up, load;
    logic [15:0] load_val;
    logic [7:0]  count0, count1;
    logic [15:0] count2, count3;
    logic [1:0]  ds0, ds1;
    logic [3:0]  ds2, ds3;
    logic [NI-1:0] carry_o;
    logic [6:0]  seg_o [NI];
    logic [31:0] obs_count [NI];
    logic [31:0] obs_dig [NI];

    int checks = 0;
    int failures = 0;
    int val_m [NI];
    bit carry_m [NI];
    int t_m = 0;

    always #5 clk = ~clk;

    counter_multidigit_sevenseg #(.DIGITS(CFG_DIG[0]), .DECIMAL(CFG_DEC[0]), .SCAN_DIV(CFG_DIV[0]), .LZ_BLANK(CFG_LZ[0]))
        u_dec2 (.clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .load_val(load_val[7:0]),
                .count(count0), .carry(carry_o[0]), .seg(seg_o[0]), .dig_sel(ds0));
    counter_multidigit_sevenseg #(.DIGITS(CFG_DIG[1]), .DECIMAL(CFG_DEC[1]), .SCAN_DIV(CFG_DIV[1]), .LZ_BLANK(CFG_LZ[1]))
        u_hex2 (.clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .load_val(load_val[7:0]),
                .count(count1), .carry(carry_o[1]), .seg(seg_o[1]), .dig_sel(ds1));
    counter_multidigit_sevenseg #(.DIGITS(CFG_DIG[2]), .DECIMAL(CFG_DEC[2]), .SCAN_DIV(CFG_DIV[2]), .LZ_BLANK(CFG_LZ[2]))
        u_scan4 (.clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .load_val(load_val),
                 .count(count2), .carry(carry_o[2]), .seg(seg_o[2]), .dig_sel(ds2));
    counter_multidigit_sevenseg #(.DIGITS(CFG_DIG[3]), .DECIMAL(CFG_DEC[3]), .SCAN_DIV(CFG_DIV[3]), .LZ_BLANK(CFG_LZ[3]))
        u_lz4 (.clk(clk), .reset(reset), .enable(enable), .up(up), .load(load), .load_val(load_val),
               .count(count3), .carry(carry_o[3]), .seg(seg_o[3]), .dig_sel(ds3));

    always_comb begin
        obs_count[0] = {24'd0, count0};
        obs_count[1] = {24'd0, count1};
        obs_count[2] = {16'd0, count2};
        obs_count[3] = {16'd0, count3};
        obs_dig[0]   = {30'd0, ds0};
        obs_dig[1]   = {30'd0, ds1};
        obs_dig[2]   = {28'd0, ds2};
        obs_dig[3]   = {28'd0, ds3};
    end

    function automatic int ipow(input int b, input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * b;
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the count is a plain integer modulo R^D; the scan position follows elapsed cycles.
    task automatic model_edge(input bit r, input bit en, input bit u, input bit ld, input logic [15:0] lv);
        for (int k = 0; k < NI; k++) begin
            int rad = CFG_DEC[k] != 0 ? 10 : 16;
            int n = ipow(rad, CFG_DIG[k]);
            if (r) begin
                val_m[k] = 0; carry_m[k] = 0;
            end else if (ld) begin
                val_m[k] = 0;
                for (int i = 0; i < CFG_DIG[k]; i++) begin
                    int nib = int'(lv >> (4 * i)) & 15;
                    if (nib >= rad) nib = 0;
                    val_m[k] += nib * ipow(rad, i);
                end
                carry_m[k] = 0;
            end else if (en) begin
                if (u) begin
                    carry_m[k] = (val_m[k] == n - 1);
                    val_m[k] = (val_m[k] + 1) % n;
                end else begin
                    carry_m[k] = (val_m[k] == 0);
                    val_m[k] = (val_m[k] + n - 1) % n;
                end
            end else begin
                carry_m[k] = 0;
            end
        end
        t_m = r ? 0 : t_m + 1;
    endtask

    function automatic int scan_pos(input int k);
        return (t_m / CFG_DIV[k]) % CFG_DIG[k];
    endfunction

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            int rad = CFG_DEC[k] != 0 ? 10 : 16;
            int idx = scan_pos(k);
            int upper = val_m[k] / ipow(rad, idx);
            logic [31:0] exp_cnt = 32'd0;
            logic [6:0] exp_seg;
            for (int i = 0; i < CFG_DIG[k]; i++)
                exp_cnt = exp_cnt | (32'((val_m[k] / ipow(rad, i)) % rad) << (4 * i));
            exp_seg = (CFG_LZ[k] != 0 && idx > 0 && upper == 0) ? 7'd0 : SEG_TAB[upper % rad];
            check_eq($sformatf("count%0d", k), obs_count[k], exp_cnt);
            check_eq($sformatf("carry%0d", k), {31'd0, carry_o[k]}, {31'd0, carry_m[k]});
            check_eq($sformatf("dig_sel%0d", k), obs_dig[k], 32'd1 << idx);
            check_eq($sformatf("seg%0d", k), {25'd0, seg_o[k]}, {25'd0, exp_seg});
        end
    endtask

    task automatic step(input bit r, input bit en, input bit u, input bit ld, input logic [15:0] lv);
        reset = r; enable = en; up = u; load = ld; load_val = lv;
        @(posedge clk);
        model_edge(r, en, u, ld, lv);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b0; load = 1'b0; load_val = 16'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("rst_seg", {25'd0, seg_o[2]}, {25'd0, 7'b1111110});
        check_eq("rst_sel", {28'd0, ds2}, 32'd1);

        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("dec_99", {24'd0, count0}, 32'h99);
        check_eq("dec_99_carry", {31'd0, carry_o[0]}, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("dec_wrap", {24'd0, count0}, 32'h00);
        check_eq("dec_wrap_carry", {31'd0, carry_o[0]}, 32'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        check_eq("dec_carry_drop", {31'd0, carry_o[0]}, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_eq("dec_borrow", {24'd0, count0}, 32'h99);
        check_eq("dec_borrow_carry", {31'd0, carry_o[0]}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_eq("dec_98", {24'd0, count0}, 32'h98);
        check_eq("dec_98_carry", {31'd0, carry_o[0]}, 32'd0);

        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h003A);
        check_eq("dec_load_3A", {24'd0, count0}, 32'h30);
        step(1'b0, 1'b1, 1'b1, 1'b1, 16'h0012);
        check_eq("dec_load_en", {24'd0, count0}, 32'h12);

        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h00FE);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("hex_FF", {24'd0, count1}, 32'hFF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        check_eq("hex_wrap", {24'd0, count1}, 32'h00);
        check_eq("hex_wrap_carry", {31'd0, carry_o[1]}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        check_eq("hex_borrow", {24'd0, count1}, 32'hFF);
        check_eq("hex_borrow_carry", {31'd0, carry_o[1]}, 32'd1);

        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0123);
        for (int i = 0; i < 18; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            check_eq("scan_sel", {28'd0, ds2}, 32'd1 << scan_pos(2));
            check_eq("scan_seg", {25'd0, seg_o[2]}, {25'd0, SCAN_0123[scan_pos(2)]});
        end

        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0007);
        for (int i = 0; i < 13; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
            check_eq("lz_seg", {25'd0, seg_o[3]}, scan_pos(3) == 0 ? 32'b1110000 : 32'd0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h5555);
        check_eq("midrst_count", {16'd0, count3}, 32'd0);
        check_eq("midrst_sel", {28'd0, ds3}, 32'd1);
        check_eq("midrst_carry", {31'd0, carry_o[3]}, 32'd0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
